// File: rtl/rx_ltssm_pkg.sv
// Shared receive-LTSSM definitions.
// Holds the ordered-set type codes, the PAD field rule codes, the per-lane
// checker state encoding and the LTSSM substate encoding shared with the
// master. Also holds the PAD rule evaluation used by every lane counter.
package rx_ltssm_pkg;

  localparam int OS_TYPE_W  = 2;
  localparam int PAD_RULE_W = 2;
  localparam int SUBSTATE_W = 4;

  typedef enum logic [OS_TYPE_W-1:0] {
    OS_NONE = 2'b00,
    OS_TS1  = 2'b01,
    OS_TS2  = 2'b10,
    OS_EIOS = 2'b11
  } os_type_e;

  typedef enum logic [PAD_RULE_W-1:0] {
    PAD_IGNORE    = 2'b00,
    PAD_BOTH      = 2'b01,
    PAD_LANE_ONLY = 2'b10,
    PAD_NONE      = 2'b11
  } pad_rule_e;

  typedef enum logic {
    LANE_CLEARED = 1'b0,
    LANE_ARMED   = 1'b1
  } lane_state_e;

  typedef enum logic [SUBSTATE_W-1:0] {
    SS_DETECT_QUIET      = 4'd0,
    SS_DETECT_ACTIVE     = 4'd1,
    SS_POLLING_ACTIVE    = 4'd2,
    SS_POLLING_CONFIG    = 4'd3,
    SS_CFG_LINKWIDTH_ST  = 4'd4,
    SS_CFG_LINKWIDTH_ACC = 4'd5,
    SS_CFG_LANENUM_WAIT  = 4'd6,
    SS_CFG_LANENUM_ACC   = 4'd7,
    SS_CFG_COMPLETE      = 4'd8,
    SS_CFG_IDLE          = 4'd9,
    SS_L0                = 4'd10
  } ltssm_substate_e;

  // Evaluates the link/lane PAD field rule for one received ordered set.
  function automatic logic pad_rule_ok(input logic [PAD_RULE_W-1:0] rule,
                                       input logic link_pad,
                                       input logic lane_pad);
    logic ok;
    ok = 1'b0;
    case (rule)
      PAD_IGNORE:    ok = 1'b1;
      PAD_BOTH:      ok = link_pad & lane_pad;
      PAD_LANE_ONLY: ok = ~link_pad & lane_pad;
      PAD_NONE:      ok = ~link_pad & ~lane_pad;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rx_os_counter_array_if.sv
// Bus between the master receive LTSSM / ordered-set decoder and the
// per-lane ordered-set counter bank.
// master: drives arm bits, target, expected type/PAD rule and decoded OS
//         pulses; receives comparator bits and per-lane counts.
// slave:  the counter bank.
interface rx_os_counter_array_if #(
  parameter int MAXLANES = 16,
  parameter int CNTW     = 5
);

  logic [MAXLANES-1:0]      resetOsCheckers;
  logic [CNTW-1:0]          comparatorsCount;
  logic [1:0]               expectedType;
  logic [1:0]               expectedPad;
  logic [MAXLANES-1:0]      osValid;
  logic [2*MAXLANES-1:0]    osType;
  logic [MAXLANES-1:0]      linkPad;
  logic [MAXLANES-1:0]      lanePad;
  logic [MAXLANES-1:0]      countersComparators;
  logic [CNTW*MAXLANES-1:0] laneCount;

  modport master (
    output resetOsCheckers, comparatorsCount, expectedType, expectedPad,
    output osValid, osType, linkPad, lanePad,
    input  countersComparators, laneCount
  );

  modport slave (
    input  resetOsCheckers, comparatorsCount, expectedType, expectedPad,
    input  osValid, osType, linkPad, lanePad,
    output countersComparators, laneCount
  );

endinterface

// File: rtl/rx_os_lane_counter.sv
// One lane of the receive ordered-set counter bank.
// Holds the frozen target, the consecutive-match counter and the registered
// comparator bit for a single lane.
// Ports:
//   clk, reset      receive clock, asynchronous active-low reset
//   arm             1 = count, 0 = held cleared with target loading
//   target_in       target count presented by the master
//   exp_type        expected OS type, exp_pad PAD field rule
//   os_valid        one-cycle pulse: an ordered set was decoded on this lane
//   os_type, link_pad, lane_pad  fields of that ordered set
//   count           registered consecutive match count
//   cmp             registered "count has reached target" bit
module rx_os_lane_counter
  import rx_ltssm_pkg::*;
#(
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            arm,
  input  logic [CNTW-1:0] target_in,
  input  logic [1:0]      exp_type,
  input  logic [1:0]      exp_pad,
  input  logic            os_valid,
  input  logic [1:0]      os_type,
  input  logic            link_pad,
  input  logic            lane_pad,
  output logic [CNTW-1:0] count,
  output logic            cmp
);

  lane_state_e     state_q, state_d;
  logic [CNTW-1:0] target_q, target_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            cmp_q, cmp_d;
  logic            match;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign match = os_valid && (os_type == exp_type) && (exp_type != OS_NONE)
                 && pad_rule_ok(exp_pad, link_pad, lane_pad);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LANE_CLEARED;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LANE_CLEARED: if (arm)  state_d = LANE_ARMED;
      LANE_ARMED:   if (!arm) state_d = LANE_CLEARED;
      default:      state_d = LANE_CLEARED;
    endcase
  end

  // Output / datapath logic, keyed on the state being entered so a clear
  // wins over a same-cycle ordered set.
  always_comb begin
    target_d = target_q;
    count_d  = count_q;
    cmp_d    = 1'b0;
    if (state_d == LANE_CLEARED) begin
      target_d = target_in;
      count_d  = '0;
    end else begin
      if (os_valid) count_d = match ? sat_inc(count_q) : '0;
      cmp_d = (count_d >= target_q) && (target_q != '0);
    end
  end

  // Lane registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q <= '0;
      count_q  <= '0;
      cmp_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
    end
  end

  assign count = count_q;
  assign cmp   = cmp_q;

endmodule

// File: rtl/rx_os_counter_array.sv
// Per-lane receive ordered-set counter bank feeding the master receive LTSSM.
// Each lane counts consecutive ordered sets matching the expected type and
// PAD rule and raises its comparator bit once the count reaches the target
// captured while the lane was cleared.
// Ports:
//   clk    receive clock
//   reset  asynchronous active-low reset
//   bus    slave side of rx_os_counter_array_if (arm bits, target, expected
//          type/PAD rule, decoded OS fields in; comparator bits, counts out)
module rx_os_counter_array
  import rx_ltssm_pkg::*;
#(
  parameter int MAXLANES = 16,
  parameter int CNTW     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  rx_os_counter_array_if.slave  bus
);

  logic [MAXLANES-1:0]      cmp_vec;
  logic [CNTW*MAXLANES-1:0] cnt_vec;

  for (genvar l = 0; l < MAXLANES; l++) begin : g_lane
    rx_os_lane_counter #(
      .CNTW(CNTW)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .arm      (bus.resetOsCheckers[l]),
      .target_in(bus.comparatorsCount),
      .exp_type (bus.expectedType),
      .exp_pad  (bus.expectedPad),
      .os_valid (bus.osValid[l]),
      .os_type  (bus.osType[2*l +: 2]),
      .link_pad (bus.linkPad[l]),
      .lane_pad (bus.lanePad[l]),
      .count    (cnt_vec[CNTW*l +: CNTW]),
      .cmp      (cmp_vec[l])
    );
  end

  assign bus.countersComparators = cmp_vec;
  assign bus.laneCount           = cnt_vec;

endmodule

// File: tb/tb_rx_os_counter_array.sv
// Directed bench for the receive ordered-set counter bank.
module tb_rx_os_counter_array;
  import rx_ltssm_pkg::*;

  localparam int MAXLANES = 16;
  localparam int CNTW     = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rx_os_counter_array_if #(.MAXLANES(MAXLANES), .CNTW(CNTW)) bus ();

  rx_os_counter_array #(
    .MAXLANES(MAXLANES),
    .CNTW    (CNTW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int l);
    return 32'(bus.laneCount[l*CNTW +: CNTW]);
  endfunction

  function automatic logic [31:0] cmpb(input int l);
    return 32'(bus.countersComparators[l]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ordered set on the masked lanes, followed by a quiet cycle's worth of
  // deasserted osValid (the caller decides whether to idle).
  task automatic pulse(input logic [15:0] mask, input logic [1:0] t,
                       input logic lp, input logic ap);
    bus.osValid = mask;
    bus.osType  = {16{t}};
    bus.linkPad = {16{lp}};
    bus.lanePad = {16{ap}};
    tick();
    bus.osValid = '0;
  endtask

  initial begin
    reset                = 1'b0;
    bus.resetOsCheckers  = '0;
    bus.comparatorsCount = '0;
    bus.expectedType     = OS_NONE;
    bus.expectedPad      = PAD_IGNORE;
    bus.osValid          = '0;
    bus.osType           = '0;
    bus.linkPad          = '0;
    bus.lanePad          = '0;

    #12;
    check("reset_cmp", 32'(bus.countersComparators), 32'h0);
    check("reset_cnt_any", 32'(|bus.laneCount), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Target 8, TS1 with both PAD fields PAD
    bus.comparatorsCount = 5'd8;
    bus.expectedType     = OS_TS1;
    bus.expectedPad      = PAD_BOTH;
    tick();
    bus.resetOsCheckers = 16'h0001;
    tick();
    for (int i = 1; i <= 8; i++) begin
      pulse(16'h0001, OS_TS1, 1'b1, 1'b1);
      check($sformatf("tgt8_cnt_%0d", i), cnt(0), 32'(i));
      check($sformatf("tgt8_cmp_%0d", i), cmpb(0), (i >= 8) ? 32'h1 : 32'h0);
      tick();
    end
    check("tgt8_cmp_vec", 32'(bus.countersComparators), 32'h0001);
    check("tgt8_other_cnts", 32'(|bus.laneCount[CNTW*MAXLANES-1:CNTW]), 32'h0);

    // Target freeze: 8 captured, master moves to 2 while armed
    bus.resetOsCheckers = 16'h0000;
    tick();
    bus.resetOsCheckers = 16'h0001;
    tick();
    bus.comparatorsCount = 5'd2;
    for (int i = 1; i <= 2; i++) begin
      pulse(16'h0001, OS_TS1, 1'b1, 1'b1);
      tick();
    end
    check("freeze_cnt", cnt(0), 32'd2);
    check("freeze_cmp", cmpb(0), 32'h0);

    // Clear in the same cycle as a matching OS
    bus.resetOsCheckers = 16'h0000;
    pulse(16'h0001, OS_TS1, 1'b1, 1'b1);
    check("clr_cnt", cnt(0), 32'd0);
    check("clr_cmp", cmpb(0), 32'h0);
    tick();
    bus.resetOsCheckers = 16'h0001;
    tick();
    bus.comparatorsCount = 5'd8;
    pulse(16'h0001, OS_TS1, 1'b1, 1'b1);
    check("newtgt_cmp_1", cmpb(0), 32'h0);
    tick();
    pulse(16'h0001, OS_TS1, 1'b1, 1'b1);
    check("newtgt_cmp_2", cmpb(0), 32'h1);

    // Asynchronous reset mid-count at 5
    bus.resetOsCheckers = 16'h0000;
    tick();
    bus.resetOsCheckers = 16'h0001;
    tick();
    for (int i = 1; i <= 5; i++) begin
      pulse(16'h0001, OS_TS1, 1'b1, 1'b1);
      tick();
    end
    check("pre_rst_cnt", cnt(0), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_cnt", 32'(|bus.laneCount), 32'h0);
    check("async_rst_cmp", 32'(bus.countersComparators), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_cnt", cnt(0), 32'd0);
    check("post_rst_cmp", 32'(bus.countersComparators), 32'h0);
    pulse(16'h0001, OS_TS1, 1'b1, 1'b1);
    check("post_rst_recount", cnt(0), 32'd1);
    check("post_rst_tgt0_cmp", cmpb(0), 32'h0);

    // Consecutiveness: target 2, TS2 expected
    bus.resetOsCheckers  = 16'h0000;
    bus.comparatorsCount = 5'd2;
    bus.expectedType     = OS_TS2;
    bus.expectedPad      = PAD_IGNORE;
    tick();
    bus.resetOsCheckers = 16'h0001;
    tick();
    pulse(16'h0001, OS_TS2, 1'b0, 1'b0);
    check("consec_cnt_a", cnt(0), 32'd1);
    check("consec_cmp_a", cmpb(0), 32'h0);
    pulse(16'h0001, OS_TS1, 1'b0, 1'b0);
    check("consec_cnt_b", cnt(0), 32'd0);
    check("consec_cmp_b", cmpb(0), 32'h0);
    pulse(16'h0001, OS_TS2, 1'b0, 1'b0);
    check("consec_cnt_c", cnt(0), 32'd1);
    check("consec_cmp_c", cmpb(0), 32'h0);
    pulse(16'h0001, OS_TS2, 1'b0, 1'b0);
    check("consec_cnt_d", cnt(0), 32'd2);
    check("consec_cmp_d", cmpb(0), 32'h1);

    // PAD rule: neither field may be PAD
    bus.resetOsCheckers  = 16'h0000;
    bus.comparatorsCount = 5'd8;
    bus.expectedType     = OS_TS1;
    bus.expectedPad      = PAD_NONE;
    tick();
    bus.resetOsCheckers = 16'h0001;
    tick();
    pulse(16'h0001, OS_TS1, 1'b0, 1'b1);
    check("pad11_lanepad_cnt", cnt(0), 32'd0);
    pulse(16'h0001, OS_TS1, 1'b0, 1'b0);
    check("pad11_nopad_cnt", cnt(0), 32'd1);
    pulse(16'h0001, OS_TS1, 1'b1, 1'b0);
    check("pad11_linkpad_cnt", cnt(0), 32'd0);

    // Target 0: saturation without comparator
    bus.resetOsCheckers  = 16'h0000;
    bus.comparatorsCount = 5'd0;
    bus.expectedPad      = PAD_IGNORE;
    tick();
    bus.resetOsCheckers = 16'h0001;
    tick();
    bus.osValid = 16'h0001;
    bus.osType  = {16{OS_TS1}};
    for (int i = 1; i <= 40; i++) begin
      tick();
      check($sformatf("tgt0_cnt_%0d", i), cnt(0), (i > 31) ? 32'd31 : 32'(i));
      check($sformatf("tgt0_cmp_%0d", i), cmpb(0), 32'h0);
    end
    bus.osValid = '0;

    // All lanes, target 2
    bus.resetOsCheckers  = 16'h0000;
    bus.comparatorsCount = 5'd2;
    tick();
    bus.resetOsCheckers = 16'hFFFF;
    tick();
    pulse(16'hFFFF, OS_TS1, 1'b0, 1'b0);
    check("all_cmp_1", 32'(bus.countersComparators), 32'h0000);
    tick();
    pulse(16'hFFFF, OS_TS1, 1'b0, 1'b0);
    check("all_cmp_2", 32'(bus.countersComparators), 32'h0000FFFF);
    for (int l = 0; l < MAXLANES; l++)
      check($sformatf("all_cnt_%0d", l), cnt(l), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
